play_sequencer: RTL and testbench



---
 rtl/play_sequencer_pkg.sv | 15 +
 rtl/play_sequencer_gap.sv | 41 ++++
 rtl/play_sequencer.sv | 145 ++++++++++++++
 tb/tb_play_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/play_sequencer_pkg.sv
// Shared state encoding and default timing constants for the playback sequencer.
package play_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_PAUSE = 3'd2,
        S_GAP   = 3'd3,
        S_NEXT  = 3'd4
    } state_t;

    localparam int GAP_CYCLES_DEFAULT = 50000000;
    localparam int GAP_BITS_DEFAULT   = 26;

endpackage

// File: rtl/play_sequencer_gap.sv
// Inter-song gap counter: clear/enable counter with terminal count at GAP_CYCLES-1.
module play_sequencer_gap
    import play_sequencer_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
    parameter int GAP_BITS   = GAP_BITS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [GAP_BITS-1:0] count_q;
    logic [GAP_BITS-1:0] count_d;

    // Next count: clear wins over enable, otherwise hold
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {GAP_BITS{1'b0}};
        end else if (enable) begin
            count_d = count_q + GAP_BITS'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {GAP_BITS{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == GAP_BITS'(GAP_CYCLES - 1));

endmodule

// File: rtl/play_sequencer.sv
// Playback controller: turns button pulses into song index, play level and
// reader restart pulses, with a silent gap and optional repeat between songs.
module play_sequencer
    import play_sequencer_pkg::*;
#(
    parameter int NUM_SONGS  = 4,
    parameter int SONG_BITS  = 2,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
    parameter int GAP_BITS   = GAP_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play_pause,
    input  logic                 next,
    input  logic                 loop_mode,
    input  logic                 song_done,
    output logic [SONG_BITS-1:0] song,
    output logic                 play,
    output logic                 restart,
    output logic                 gap_active
);

    state_t               state_q, state_d;
    logic [SONG_BITS-1:0] song_q, song_d;
    logic                 adv_q, adv_d;
    logic                 resume_q, resume_d;
    logic                 play_q, restart_q, gap_active_q;
    logic                 gap_tc;

    play_sequencer_gap #(
        .GAP_CYCLES (GAP_CYCLES),
        .GAP_BITS   (GAP_BITS)
    ) u_gap (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != S_GAP),
        .enable (state_q == S_GAP),
        .tc     (gap_tc)
    );

    // Next-state, advance/resume bookkeeping and song update
    always_comb begin
        state_d  = state_q;
        adv_d    = adv_q;
        resume_d = resume_q;
        song_d   = song_q;
        case (state_q)
            S_IDLE: begin
                if (next) begin
                    state_d  = S_NEXT;
                    adv_d    = 1'b1;
                    resume_d = 1'b0;
                end else if (play_pause) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (next) begin
                    state_d  = S_NEXT;
                    adv_d    = 1'b1;
                    resume_d = 1'b1;
                end else if (play_pause) begin
                    state_d = S_PAUSE;
                end else if (song_done) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_PAUSE: begin
                if (next) begin
                    state_d  = S_NEXT;
                    adv_d    = 1'b1;
                    resume_d = 1'b0;
                end else if (play_pause) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_GAP: begin
                if (next) begin
                    state_d  = S_NEXT;
                    adv_d    = 1'b1;
                    resume_d = 1'b1;
                end else if (gap_tc) begin
                    state_d  = S_NEXT;
                    adv_d    = ~loop_mode;
                    resume_d = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_NEXT: begin
                // Index changes here so it lands together with play, ahead of note 0
                if (adv_q) begin
                    if (song_q == SONG_BITS'(NUM_SONGS - 1)) begin
                        song_d = {SONG_BITS{1'b0}};
                    end else begin
                        song_d = song_q + SONG_BITS'(1);
                    end
                end else begin
                    song_d = song_q;
                end
                if (resume_q) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, song and Moore-decoded output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            song_q       <= {SONG_BITS{1'b0}};
            adv_q        <= 1'b0;
            resume_q     <= 1'b0;
            play_q       <= 1'b0;
            restart_q    <= 1'b0;
            gap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            adv_q        <= adv_d;
            resume_q     <= resume_d;
            play_q       <= (state_d == S_PLAY);
            restart_q    <= (state_d == S_NEXT);
            gap_active_q <= (state_d == S_GAP);
        end
    end

    assign song       = song_q;
    assign play       = play_q;
    assign restart    = restart_q;
    assign gap_active = gap_active_q;

endmodule

// File: tb/tb_play_sequencer.sv
// Directed-vector bench for play_sequencer; expectations queued per cycle, checked by a monitor.
module tb_play_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play_pause = 1'b0;
    logic       next = 1'b0;
    logic       loop_mode = 1'b0;
    logic       song_done = 1'b0;
    logic [1:0] song;
    logic       play;
    logic       restart;
    logic       gap_active;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] id;
        logic [4:0]  exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int edges  = 0;
    int vec_id = 0;
    int checks = 0;
    int errors = 0;

    play_sequencer #(
        .NUM_SONGS  (4),
        .SONG_BITS  (2),
        .GAP_CYCLES (4),
        .GAP_BITS   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .play_pause (play_pause),
        .next       (next),
        .loop_mode  (loop_mode),
        .song_done  (song_done),
        .song       (song),
        .play       (play),
        .restart    (restart),
        .gap_active (gap_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges = edges + 1;

    // Monitor: compare every expectation that is due at this negedge
    always @(negedge clk) begin
        sb_entry_t e;
        logic [4:0] act;
        act = {song, play, restart, gap_active};
        while (sb_q.size() > 0 && int'(sb_q[0].cyc) <= edges) begin
            e = sb_q.pop_front();
            checks = checks + 1;
            if (int'(e.cyc) != edges || act !== e.exp) begin
                errors = errors + 1;
                $display("FAIL vec%0d cycle %0d: got song=%0d play=%0b restart=%0b gap=%0b, expected song=%0d play=%0b restart=%0b gap=%0b",
                         e.id, edges, act[4:3], act[2], act[1], act[0],
                         e.exp[4:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    end

    // One cycle: drive inputs, queue the outputs expected after the next posedge
    task automatic v(input logic rs, input logic pp, input logic nx, input logic sd,
                     input logic [1:0] s, input logic p, input logic r, input logic g);
        sb_entry_t e;
        reset      = rs;
        play_pause = pp;
        next       = nx;
        song_done  = sd;
        e.cyc = 32'(edges + 1);
        e.id  = 32'(vec_id);
        e.exp = {s, p, r, g};
        sb_q.push_back(e);
        vec_id = vec_id + 1;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [1:0] s, input logic p, input logic g);
        for (int i = 0; i < n; i++) v(1'b0, 1'b0, 1'b0, 1'b0, s, p, 1'b0, g);
    endtask

    initial begin
        // Reset and quiet idle
        v(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        v(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(10, 2'd0, 1'b0, 1'b0);

        // Play / pause / play without restart
        v(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(4, 2'd0, 1'b1, 1'b0);
        v(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(2, 2'd0, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        idle(1, 2'd0, 1'b1, 1'b0);

        // Song end, advance: 4 gap cycles, one restart, then song 1 playing
        v(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(3, 2'd0, 1'b0, 1'b1);
        v(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd1, 1'b1, 1'b0);

        // Skip to song 3, then song end wraps to 0
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd2, 1'b1, 1'b0);
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd3, 1'b1, 1'b0);
        v(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        idle(3, 2'd3, 1'b0, 1'b1);
        v(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd0, 1'b1, 1'b0);

        // To song 2, then repeat it with loop_mode
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd1, 1'b1, 1'b0);
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd2, 1'b1, 1'b0);
        loop_mode = 1'b1;
        v(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        idle(3, 2'd2, 1'b0, 1'b1);
        v(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        loop_mode = 1'b0;
        idle(1, 2'd2, 1'b1, 1'b0);

        // To song 1, pause, song_done ignored, next while paused stays paused
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd3, 1'b1, 1'b0);
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd0, 1'b1, 1'b0);
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd1, 1'b1, 1'b0);
        v(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        idle(2, 2'd2, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);

        // Simultaneous next+play_pause, then next+song_done: single advance each
        v(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd3, 1'b1, 1'b0);
        v(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd0, 1'b1, 1'b0);

        // In gap: play_pause ignored, next cuts the gap short
        v(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        v(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd1, 1'b1, 1'b0);

        // Reset mid-gap, then next from idle lands paused on song 1
        v(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        idle(1, 2'd1, 1'b0, 1'b1);
        v(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(1, 2'd0, 1'b0, 1'b0);
        v(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle(1, 2'd1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);

        // Reset mid-song
        v(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(2, 2'd0, 1'b0, 1'b0);

        @(negedge clk);
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
